// File: rtl/cpu_main_mc.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/EXEC(/MEM) sequencing, register file, data memory and tristate I/O port.
// Optional macro CPU_MAIN_MC_PORT_HS_EN adds a PORT_VLD/PORT_STB handshake on the I/O port.
module cpu_main_mc #(
    parameter int IWIDTH     = 5,
    parameter int DWIDTH     = 8,
    parameter int REG_NUM    = 8,
    parameter int DMEM_DEPTH = 256,
    parameter int PC_WIDTH   = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    output logic [PC_WIDTH-1:0]      IMEM_ADDR,
    output logic                     IMEM_RD,
    input  logic [IWIDTH+DWIDTH-1:0] IMEM_DATA,
    inout  wire  [DWIDTH-1:0]        PORT,
`ifdef CPU_MAIN_MC_PORT_HS_EN
    input  logic                     PORT_VLD,
    output logic                     PORT_STB,
`endif
    output logic                     HALTED,
    output logic [DWIDTH-1:0]        ACC_DBG
);

    localparam int RW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    localparam logic [IWIDTH-1:0] OP_LDI = IWIDTH'(32'h01);
    localparam logic [IWIDTH-1:0] OP_LDR = IWIDTH'(32'h02);
    localparam logic [IWIDTH-1:0] OP_STR = IWIDTH'(32'h03);
    localparam logic [IWIDTH-1:0] OP_LDM = IWIDTH'(32'h04);
    localparam logic [IWIDTH-1:0] OP_STM = IWIDTH'(32'h05);
    localparam logic [IWIDTH-1:0] OP_ADD = IWIDTH'(32'h06);
    localparam logic [IWIDTH-1:0] OP_SUB = IWIDTH'(32'h07);
    localparam logic [IWIDTH-1:0] OP_AND = IWIDTH'(32'h08);
    localparam logic [IWIDTH-1:0] OP_OR  = IWIDTH'(32'h09);
    localparam logic [IWIDTH-1:0] OP_XOR = IWIDTH'(32'h0A);
    localparam logic [IWIDTH-1:0] OP_JMP = IWIDTH'(32'h0B);
    localparam logic [IWIDTH-1:0] OP_JZ  = IWIDTH'(32'h0C);
    localparam logic [IWIDTH-1:0] OP_IN  = IWIDTH'(32'h0D);
    localparam logic [IWIDTH-1:0] OP_OUT = IWIDTH'(32'h0E);
    localparam logic [IWIDTH-1:0] OP_HLT = IWIDTH'(32'h1F);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALT} state_t;

    state_t                     state;
    logic [PC_WIDTH-1:0]        pc;
    logic [DWIDTH-1:0]          acc;
    logic                       z;
    logic [IWIDTH+DWIDTH-1:0]   ir;
    logic                       port_oe;
    logic [DWIDTH-1:0]          port_out;
    logic                       halted;
    logic                       imem_rd;
    logic [DWIDTH-1:0]          regs [REG_NUM];
    logic [DWIDTH-1:0]          dmem [DMEM_DEPTH];
    logic [DWIDTH-1:0]          dmem_q;

    logic [IWIDTH-1:0]          opcode;
    logic [DWIDTH-1:0]          k;
    logic [RW-1:0]              r;
    logic [DWIDTH-1:0]          rval;
    logic                       k_in_range;
    logic [DWIDTH-1:0]          alu_res;
    logic                       alu_wr;
    logic                       in_ok;

    assign opcode     = ir[IWIDTH+DWIDTH-1:DWIDTH];
    assign k          = ir[DWIDTH-1:0];
    assign r          = k[RW-1:0];
    assign rval       = regs[r];
    assign k_in_range = (32'(k) < DMEM_DEPTH);

`ifdef CPU_MAIN_MC_PORT_HS_EN
    assign in_ok = PORT_VLD;
`else
    assign in_ok = 1'b1;
`endif

    always_comb begin
        alu_res = acc;
        alu_wr  = 1'b0;
        case (opcode)
            OP_LDI: begin alu_res = k;          alu_wr = 1'b1; end
            OP_LDR: begin alu_res = rval;       alu_wr = 1'b1; end
            OP_ADD: begin alu_res = acc + rval; alu_wr = 1'b1; end
            OP_SUB: begin alu_res = acc - rval; alu_wr = 1'b1; end
            OP_AND: begin alu_res = acc & rval; alu_wr = 1'b1; end
            OP_OR:  begin alu_res = acc | rval; alu_wr = 1'b1; end
            OP_XOR: begin alu_res = acc ^ rval; alu_wr = 1'b1; end
            default: ;
        endcase
    end

    // Reset aborts anything in flight; IMEM_RD is registered alongside the move into FETCH.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= FETCH;
            imem_rd  <= 1'b1;
            pc       <= '0;
            acc      <= '0;
            z        <= 1'b0;
            ir       <= '0;
            port_oe  <= 1'b0;
            port_out <= '0;
            halted   <= 1'b0;
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
`ifdef CPU_MAIN_MC_PORT_HS_EN
            PORT_STB <= 1'b0;
`endif
        end else begin
            imem_rd <= 1'b0;
`ifdef CPU_MAIN_MC_PORT_HS_EN
            PORT_STB <= 1'b0;
`endif
            case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    ir    <= IMEM_DATA;
                    pc    <= pc + 1'b1;
                    state <= EXEC;
`ifdef CPU_MAIN_MC_PORT_HS_EN
                    PORT_STB <= (IMEM_DATA[IWIDTH+DWIDTH-1:DWIDTH] == OP_OUT);
`endif
                end
                EXEC: begin
                    state   <= FETCH;
                    imem_rd <= 1'b1;
                    if (alu_wr) begin
                        acc <= alu_res;
                        z   <= (alu_res == '0);
                    end
                    case (opcode)
                        OP_STR: regs[r] <= acc;
                        OP_LDM: begin state <= MEM; imem_rd <= 1'b0; end
                        OP_JMP: pc <= PC_WIDTH'(k);
                        OP_JZ:  if (z) pc <= PC_WIDTH'(k);
                        OP_IN: begin
                            if (in_ok) begin
                                acc     <= PORT;
                                z       <= (PORT == '0);
                                port_oe <= 1'b0;
                            end else begin
                                state   <= EXEC;
                                imem_rd <= 1'b0;
                            end
                        end
                        OP_OUT: begin port_out <= acc; port_oe <= 1'b1; end
                        OP_HLT: begin state <= HALT; imem_rd <= 1'b0; halted <= 1'b1; end
                        default: ;
                    endcase
                end
                MEM: begin
                    acc     <= dmem_q;
                    z       <= (dmem_q == '0);
                    state   <= FETCH;
                    imem_rd <= 1'b1;
                end
                HALT:    state <= HALT;
                default: begin state <= FETCH; imem_rd <= 1'b1; end
            endcase
        end
    end

    // Data memory survives reset; out-of-range addresses read zero and ignore writes.
    always_ff @(posedge CLK) begin
        if (!RST && state == EXEC && opcode == OP_STM && k_in_range)
            dmem[k[AW-1:0]] <= acc;
        dmem_q <= k_in_range ? dmem[k[AW-1:0]] : '0;
    end

    assign PORT      = port_oe ? port_out : {DWIDTH{1'bz}};
    assign IMEM_ADDR = pc;
    assign IMEM_RD   = imem_rd;
    assign HALTED    = halted;
    assign ACC_DBG   = acc;

endmodule

// File: tb/tb_cpu_main_mc.sv
// Directed scoreboard bench for cpu_main_mc: small programs, expectations queued per cycle and checked at the negedge.
// Handshake scenarios compile only with CPU_MAIN_MC_PORT_HS_EN.
module tb_cpu_main_mc;

    localparam logic [4:0] NOP = 5'h00, LDI = 5'h01, LDR = 5'h02, STR = 5'h03, LDM = 5'h04,
                           STM = 5'h05, ADD = 5'h06, SUB = 5'h07, AND = 5'h08, OR = 5'h09,
                           XOR = 5'h0A, JMP = 5'h0B, JZ = 5'h0C, IN = 5'h0D, OUT = 5'h0E,
                           HLT = 5'h1F;
    localparam int S_ACC = 0, S_ADDR = 1, S_RD = 2, S_HALT = 3, S_PORT = 4, S_REL = 5, S_STB = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [12:0] imem_data = '0;
    wire  [7:0]  port_bus;
    logic        halted;
    logic [7:0]  acc_dbg;
    logic        drv_en = 1'b0;
    logic [7:0]  drv_val = '0;
    logic        port_vld = 1'b1;
`ifdef CPU_MAIN_MC_PORT_HS_EN
    logic        port_stb;
`endif

    logic [12:0] prog [256];

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   drv_from = 0, drv_to = 0, vld_from = 0;

    always #5 clk = ~clk;

    assign port_bus = drv_en ? drv_val : 8'hzz;

    always @(posedge clk) if (imem_rd) imem_data <= prog[imem_addr];

    cpu_main_mc dut (
        .CLK       (clk),
        .RST       (rst),
        .IMEM_ADDR (imem_addr),
        .IMEM_RD   (imem_rd),
        .IMEM_DATA (imem_data),
        .PORT      (port_bus),
`ifdef CPU_MAIN_MC_PORT_HS_EN
        .PORT_VLD  (port_vld),
        .PORT_STB  (port_stb),
`endif
        .HALTED    (halted),
        .ACC_DBG   (acc_dbg)
    );

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = '0;
        drv_from = 0; drv_to = 0; vld_from = 0; drv_val = '0;
        drv_en = 1'b0; port_vld = 1'b1;
    endtask

    task automatic applyStimulus(input int addr, input logic [4:0] op, input logic [7:0] k);
        prog[addr] = {op, k};
    endtask

    task automatic expect_at(input int c, input int sel, input logic [7:0] e, input string tag);
        exp_t x;
        x.cyc = c; x.sel = sel; x.exp = e; x.tag = tag;
        sb.push_back(x);
    endtask

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            S_ACC:  return acc_dbg;
            S_ADDR: return imem_addr;
            S_RD:   return {7'b0, imem_rd};
            S_HALT: return {7'b0, halted};
            S_PORT: return port_bus;
            S_REL:  return {7'b0, ((port_bus === 8'hzz) || (port_bus === 8'h00))};
`ifdef CPU_MAIN_MC_PORT_HS_EN
            S_STB:  return {7'b0, port_stb};
`endif
            default: return 8'hxx;
        endcase
    endfunction

    task automatic checkOutput();
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t       x;
            logic [7:0] obs;
            x   = sb.pop_front();
            obs = observe(x.sel);
            vectors++;
            assert (obs === x.exp) else begin
                miscompares++;
                $error("[TB] FAIL %s @cyc %0d: observed %h expected %h", x.tag, cyc, obs, x.exp);
            end
        end
    endtask

    task automatic update_drive();
        drv_en   = (cyc >= drv_from) && (cyc < drv_to);
        port_vld = (cyc >= vld_from);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run(input int n);
        checkOutput();
        update_drive();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            checkOutput();
            update_drive();
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard: %0d expectations left unchecked, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        // ADD without wrap; JZ must not be taken while Z=0
        clear_prog();
        applyStimulus(0, LDI, 8'h05); applyStimulus(1, STR, 8'h01);
        applyStimulus(2, LDI, 8'h03); applyStimulus(3, ADD, 8'h01);
        applyStimulus(4, JZ,  8'h30);
        expect_at(0,  S_ADDR, 8'h00, "rst_addr");
        expect_at(0,  S_RD,   8'h01, "rst_rd");
        expect_at(0,  S_ACC,  8'h00, "rst_acc");
        expect_at(0,  S_HALT, 8'h00, "rst_halted");
        expect_at(1,  S_RD,   8'h00, "rd_one_cycle");
        expect_at(3,  S_ACC,  8'h05, "ldi_05");
        expect_at(12, S_ACC,  8'h08, "add_08");
        expect_at(15, S_ADDR, 8'h05, "jz_not_taken");
        do_reset();
        run(15);

        // ADD wrap sets Z, JZ taken into a HLT
        clear_prog();
        applyStimulus(0, LDI, 8'hFF); applyStimulus(1, STR, 8'h02);
        applyStimulus(2, LDI, 8'h01); applyStimulus(3, ADD, 8'h02);
        applyStimulus(4, JZ,  8'h20); applyStimulus(8'h20, HLT, 8'h00);
        expect_at(12, S_ACC,  8'h00, "add_wrap");
        expect_at(15, S_ADDR, 8'h20, "jz_taken");
        expect_at(15, S_RD,   8'h01, "jz_fetch_rd");
        expect_at(18, S_HALT, 8'h01, "halted");
        expect_at(18, S_RD,   8'h00, "halt_rd_a");
        expect_at(28, S_RD,   8'h00, "halt_rd_b");
        expect_at(38, S_RD,   8'h00, "halt_rd_c");
        expect_at(38, S_HALT, 8'h01, "halt_held");
        expect_at(38, S_ADDR, 8'h21, "halt_pc_held");
        do_reset();
        run(38);

        // Reset exits HALT and clears registers; STM/LDM round trip with 4-cycle LDM
        clear_prog();
        applyStimulus(0, LDI, 8'h77); applyStimulus(1, LDR, 8'h02);
        applyStimulus(2, LDI, 8'hA5); applyStimulus(3, STM, 8'h10);
        applyStimulus(4, LDI, 8'h00); applyStimulus(5, LDM, 8'h10);
        expect_at(0,  S_HALT, 8'h00, "unhalt");
        expect_at(0,  S_ADDR, 8'h00, "unhalt_addr");
        expect_at(3,  S_ACC,  8'h77, "ldi_77");
        expect_at(6,  S_ACC,  8'h00, "reg_cleared");
        expect_at(9,  S_ACC,  8'hA5, "ldi_a5");
        expect_at(15, S_ACC,  8'h00, "ldi_00");
        expect_at(18, S_ACC,  8'h00, "ldm_not_yet");
        expect_at(19, S_ACC,  8'hA5, "ldm_a5");
        expect_at(19, S_ADDR, 8'h06, "ldm_next_fetch");
        expect_at(19, S_RD,   8'h01, "ldm_next_rd");
        do_reset();
        run(19);

        // DMEM survives reset; OUT drives the port, IN releases it and samples external data
        clear_prog();
        applyStimulus(0, LDM, 8'h10); applyStimulus(1, LDI, 8'h3C);
        applyStimulus(2, OUT, 8'h00); applyStimulus(3, IN,  8'h00);
        applyStimulus(4, IN,  8'h00);
        drv_from = 14; drv_to = 16; drv_val = 8'h81;
        expect_at(4,  S_ACC,  8'hA5, "dmem_kept");
        expect_at(7,  S_ACC,  8'h3C, "ldi_3c");
        expect_at(10, S_PORT, 8'h3C, "out_drive");
        expect_at(13, S_ACC,  8'h3C, "in_own");
        expect_at(13, S_REL,  8'h01, "port_released");
        expect_at(16, S_ACC,  8'h81, "in_ext_81");
        expect_at(17, S_REL,  8'h01, "port_still_free");
`ifdef CPU_MAIN_MC_PORT_HS_EN
        expect_at(8,  S_STB,  8'h00, "stb_before");
        expect_at(9,  S_STB,  8'h01, "stb_exec");
        expect_at(10, S_STB,  8'h00, "stb_after");
`endif
        do_reset();
        run(17);

        // Remaining ALU ops, unknown opcode as NOP holding Z, JMP and PC wrap
        clear_prog();
        applyStimulus(0, LDI, 8'h0F); applyStimulus(1, STR, 8'h03);
        applyStimulus(2, LDI, 8'h3C); applyStimulus(3, SUB, 8'h03);
        applyStimulus(4, AND, 8'h03); applyStimulus(5, OR,  8'h03);
        applyStimulus(6, XOR, 8'h03); applyStimulus(7, 5'h15, 8'h77);
        applyStimulus(8, JZ,  8'h50); applyStimulus(8'h50, JMP, 8'hFF);
        applyStimulus(8'hFF, LDI, 8'h11);
        expect_at(12, S_ACC,  8'h2D, "sub");
        expect_at(15, S_ACC,  8'h0D, "and");
        expect_at(18, S_ACC,  8'h0F, "or");
        expect_at(21, S_ACC,  8'h00, "xor");
        expect_at(24, S_ACC,  8'h00, "undef_nop");
        expect_at(27, S_ADDR, 8'h50, "jz_after_nop");
        expect_at(30, S_ADDR, 8'hFF, "jmp");
        expect_at(33, S_ACC,  8'h11, "ldi_at_ff");
        expect_at(33, S_ADDR, 8'h00, "pc_wrap");
        do_reset();
        run(33);

`ifdef CPU_MAIN_MC_PORT_HS_EN
        // IN stalls until PORT_VLD, then OUT strobes for its EXEC cycle
        clear_prog();
        applyStimulus(0, IN, 8'h00); applyStimulus(1, OUT, 8'h00);
        vld_from = 7; drv_from = 7; drv_to = 8; drv_val = 8'h42;
        expect_at(5,  S_RD,   8'h00, "stall_rd");
        expect_at(7,  S_ACC,  8'h00, "stall_acc");
        expect_at(8,  S_ACC,  8'h42, "hs_in_42");
        expect_at(9,  S_STB,  8'h00, "hs_stb_dec");
        expect_at(10, S_STB,  8'h01, "hs_stb_exec");
        expect_at(11, S_STB,  8'h00, "hs_stb_off");
        expect_at(11, S_PORT, 8'h42, "hs_out_42");
        do_reset();
        run(11);

        // Reset during the IN stall restarts cleanly
        clear_prog();
        applyStimulus(0, IN, 8'h00);
        vld_from = 1000;
        expect_at(5, S_RD,  8'h00, "stall_pre_rst");
        expect_at(5, S_ACC, 8'h00, "stall_acc_pre_rst");
        do_reset();
        run(5);
        expect_at(0, S_ADDR, 8'h00, "stall_rst_pc");
        expect_at(0, S_ACC,  8'h00, "stall_rst_acc");
        expect_at(0, S_STB,  8'h00, "stall_rst_stb");
        do_reset();
        run(1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_main_mc.md
CPU_MAIN_MC -- requirements
Module: cpu_main_mc

Interface
REQ-001 Parameters SHALL be, one per line:
- IWIDTH, 5, opcode width
- DWIDTH, 8, data/operand width
- REG_NUM, 8, register file entries (power of 2, ≤ 2^DWIDTH)
- DMEM_DEPTH, 256, data memory words (≤ 2^DWIDTH)
- PC_WIDTH, 8, program counter width
REQ-002 The block has one clock, CLK. Reset RST is synchronous and active-high.
REQ-003 Ports SHALL be:
- CLK  in  1  clock
- RST  in  1  sync active-high reset
- IMEM_ADDR  out  PC_WIDTH  instruction address
- IMEM_RD  out  1  instruction read strobe
- IMEM_DATA  in  IWIDTH+DWIDTH  instruction word {opcode, operand}; valid one cycle after IMEM_RD
- PORT  inout  DWIDTH  I/O port; drives PORT_OUT when PORT_OE=1, else Z
- HALTED  out  1  core stopped
- ACC_DBG  out  DWIDTH  accumulator value

Function
REQ-004 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM and HALT. The transitions are FETCH→DECODE→EXEC→FETCH; for LDM, EXEC→MEM→FETCH; for HLT, EXEC→HALT.
REQ-005 In FETCH, IMEM_ADDR=PC and IMEM_RD=1 for exactly one cycle. IMEM_RD=0 in all other states.
REQ-006 In DECODE, IR<=IMEM_DATA and PC<=PC+1, modulo 2^PC_WIDTH (wraps from all-ones to 0).
REQ-007 Opcodes (hex) and EXEC actions, with r=operand[log2(REG_NUM)-1:0] and k=operand:
- 00 NOP: no action
- 01 LDI: ACC<=k
- 02 LDR: ACC<=R[r]
- 03 STR: R[r]<=ACC
- 04 LDM: read DMEM[k]; ACC<=data in MEM
- 05 STM: DMEM[k]<=ACC
- 06 ADD: ACC<=ACC+R[r]
- 07 SUB: ACC<=ACC-R[r]
- 08 AND, 09 OR, 0A XOR: ACC<=ACC op R[r]
- 0B JMP: PC<=k
- 0C JZ: PC<=k if Z=1
- 0D IN: ACC<=PORT; PORT_OE<=0
- 0E OUT: PORT_OUT<=ACC; PORT_OE<=1
- 1F HLT
REQ-008 Any other opcode SHALL execute as NOP.
REQ-009 ALU results SHALL be truncated to DWIDTH bits (carry/borrow discarded).
REQ-010 Z SHALL update to (new ACC==0) on LDI, LDR, LDM, ADD, SUB, AND, OR, XOR and IN. All other instructions hold Z.
REQ-011 Data memory SHALL be synchronous read with 1-cycle latency and synchronous write. Addresses ≥ DMEM_DEPTH SHALL read 0 and drop writes.
REQ-012 Latency SHALL be 3 cycles per instruction, 4 cycles for LDM, excluding stalls.
REQ-013 JMP/JZ to address k SHALL cause the next FETCH to present k on IMEM_ADDR. PC_WIDTH>DWIDTH SHALL zero-extend k.
REQ-014 In HALT, HALTED=1 and the block SHALL hold all state. Only RST exits HALT.
REQ-015 ACC_DBG SHALL equal ACC at all times.

Reset
REQ-016 While RST=1 at a CLK edge: PC=0, ACC=0, Z=0, IR=0, PORT_OE=0, PORT_OUT=0, HALTED=0, state=FETCH. All registers R[*] SHALL be 0. DMEM contents SHALL be unchanged.
REQ-017 RST in any state, including MEM, a mid-HALT state or the stall of REQ-019, SHALL abort the current instruction with no register, memory or PC side effect. Fetch SHALL restart from PC=0 in the first cycle after RST falls.

Configuration
REQ-018 Macro CPU_MAIN_MC_PORT_HS_EN, when defined, SHALL add these ports:
- PORT_VLD  in  1  input data valid
- PORT_STB  out  1  output write strobe
REQ-019 With CPU_MAIN_MC_PORT_HS_EN defined:
- IN SHALL stall in EXEC until PORT_VLD=1, then capture PORT that cycle.
- OUT SHALL pulse PORT_STB=1 for exactly the EXEC cycle.
- PORT_STB SHALL reset to 0.
REQ-020 Without CPU_MAIN_MC_PORT_HS_EN, those ports SHALL not exist, IN SHALL sample PORT in EXEC with no stall, and behaviour SHALL otherwise be identical.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- LDI 05; STR 1; LDI 03; ADD 1 → ACC_DBG=08, Z=0, 12 cycles after reset release.
- LDI FF; STR 2; LDI 01; ADD 2 → ACC_DBG=00, Z=1 (wrap). JZ 20 → IMEM_ADDR=20 at next FETCH.
- LDI A5; STM 10; LDI 00; LDM 10 → ACC_DBG=A5, with the LDM taking 4 cycles.
- LDI 3C; OUT → PORT=3C driven. IN with external PORT=81 → ACC_DBG=81, PORT released to Z.
- HLT → HALTED=1, IMEM_RD stays 0 for 20 cycles. RST pulse → HALTED=0, IMEM_ADDR=00.
- With CPU_MAIN_MC_PORT_HS_EN: IN with PORT_VLD low for 5 cycles, then PORT_VLD=1 and PORT=42 → ACC_DBG=42 exactly one cycle later. RST asserted during the stall → PC=0 and ACC unchanged from reset value.
